// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared sizes, register index/data types and the r0 constant.
package wb_regfile_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_ADDR_W = 4;
  localparam int XLEN = 32;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;
  localparam reg_idx_t R0 = '0;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback, read-port and issue/hazard signals between pipeline and register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;
  xlen_t wb_data_in;
  logic wb_write_in;
  reg_idx_t wb_rd_in;
  reg_idx_t rs_a_in;
  reg_idx_t rs_b_in;
  xlen_t rs_a_data_out;
  xlen_t rs_b_data_out;
  logic issue_valid_in;
  logic issue_writes_in;
  reg_idx_t issue_rd_in;
  logic use_a_in;
  logic use_b_in;
  logic hazard_out;
  modport master (
    output wb_data_in, wb_write_in, wb_rd_in, rs_a_in, rs_b_in,
    output issue_valid_in, issue_writes_in, issue_rd_in, use_a_in, use_b_in,
    input rs_a_data_out, rs_b_data_out, hazard_out
  );
  modport slave (
    input wb_data_in, wb_write_in, wb_rd_in, rs_a_in, rs_b_in,
    input issue_valid_in, issue_writes_in, issue_rd_in, use_a_in, use_b_in,
    output rs_a_data_out, rs_b_data_out, hazard_out
  );
endinterface

// File: rtl/wb_regfile_reg_scoreboard.sv
// reg_scoreboard: per-register pending bits; set on issue, cleared on retire, set wins, r0 never pending.
module reg_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  output logic [NUM_REGS-1:0] pending
);
  logic [NUM_REGS-1:0] pending_q, pending_d;
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    if (set_en) pending_d[set_idx] = 1'b1;
    pending_d[R0] = 1'b0;
  end
  always_ff @(posedge clk) pending_q <= reset ? '0 : pending_d;
  assign pending = pending_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 16x32 register file with two combinational reads, write scoreboard and hazard flag.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  xlen_t regs_q [NUM_REGS];
  xlen_t regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic wr_en, hit_a, hit_b;
  assign wr_en = bus.wb_write_in && (bus.wb_rd_in != R0);
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[bus.wb_rd_in] = bus.wb_data_in;
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
`ifdef REGFILE_BYPASS_EN
  assign hit_a = wr_en && (bus.rs_a_in == bus.wb_rd_in);
  assign hit_b = wr_en && (bus.rs_b_in == bus.wb_rd_in);
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif
  assign bus.rs_a_data_out = hit_a ? bus.wb_data_in : regs_q[bus.rs_a_in];
  assign bus.rs_b_data_out = hit_b ? bus.wb_data_in : regs_q[bus.rs_b_in];
  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (bus.issue_valid_in && bus.issue_writes_in),
    .set_idx (bus.issue_rd_in),
    .clr_en  (bus.wb_write_in),
    .clr_idx (bus.wb_rd_in),
    .pending (pending)
  );
  assign bus.hazard_out = (bus.use_a_in && pending[bus.rs_a_in] && !hit_a) ||
                          (bus.use_b_in && pending[bus.rs_b_in] && !hit_b);
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed steps with a queue of expected read/hazard values compared after each step.
module tb_wb_regfile;
  import wb_regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    string tag;
    xlen_t a;
    xlen_t b;
    logic  h;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  wb_regfile_if bus ();
  wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic wr, input reg_idx_t rd, input xlen_t d,
                     input reg_idx_t ra, input logic ua, input reg_idx_t rb, input logic ub,
                     input logic iv, input reg_idx_t ird);
    bus.wb_write_in = wr;
    bus.wb_rd_in = rd;
    bus.wb_data_in = d;
    bus.rs_a_in = ra;
    bus.use_a_in = ua;
    bus.rs_b_in = rb;
    bus.use_b_in = ub;
    bus.issue_valid_in = iv;
    bus.issue_writes_in = iv;
    bus.issue_rd_in = ird;
  endtask
  task automatic expect_out(input string tag, input xlen_t a, input xlen_t b, input logic h);
    exp_t e;
    e.tag = tag;
    e.a = a;
    e.b = b;
    e.h = h;
    q.push_back(e);
  endtask
  task automatic chk();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert (bus.rs_a_data_out === e.a) else begin
        failures++;
        $error("FAIL %s rs_a_data_out got=%h exp=%h", e.tag, bus.rs_a_data_out, e.a);
      end
      checks++;
      assert (bus.rs_b_data_out === e.b) else begin
        failures++;
        $error("FAIL %s rs_b_data_out got=%h exp=%h", e.tag, bus.rs_b_data_out, e.b);
      end
      checks++;
      assert (bus.hazard_out === e.h) else begin
        failures++;
        $error("FAIL %s hazard_out got=%b exp=%b", e.tag, bus.hazard_out, e.h);
      end
    end
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      drv(0, 0, 0, reg_idx_t'(i), 1, reg_idx_t'(15 - i), 1, 0, 0);
      expect_out("reset_read", 0, 0, 0);
      chk();
    end
    drv(1, 5, 32'hDEADBEEF, 5, 0, 5, 0, 0, 0);
    expect_out("wr_r5_same", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 0);
    chk();
    tick();
    drv(1, 0, 32'h1234, 5, 1, 0, 1, 0, 0);
    expect_out("rd_r5_wr_r0", 32'hDEADBEEF, 0, 0);
    chk();
    tick();
    drv(0, 0, 0, 0, 1, 5, 0, 0, 0);
    expect_out("r0_ignored", 0, 32'hDEADBEEF, 0);
    chk();
    drv(0, 0, 0, 3, 0, 3, 0, 1, 3);
    expect_out("issue_r3", 0, 0, 0);
    chk();
    tick();
    drv(0, 0, 0, 3, 1, 5, 1, 0, 0);
    expect_out("r3_pending", 0, 32'hDEADBEEF, 1);
    chk();
    tick();
    drv(1, 3, 32'hCAFEF00D, 3, 1, 0, 0, 0, 0);
    expect_out("r3_retire", BYP ? 32'hCAFEF00D : 32'h0, 0, !BYP);
    chk();
    tick();
    drv(0, 0, 0, 3, 1, 3, 1, 0, 0);
    expect_out("r3_done", 32'hCAFEF00D, 32'hCAFEF00D, 0);
    chk();
    drv(1, 7, 32'h77, 7, 0, 7, 0, 1, 7);
    expect_out("r7_set_clr", BYP ? 32'h77 : 32'h0, BYP ? 32'h77 : 32'h0, 0);
    chk();
    tick();
    drv(0, 0, 0, 7, 1, 0, 0, 0, 0);
    expect_out("r7_set_wins", 32'h77, 0, 1);
    chk();
    tick();
    drv(1, 7, 32'h78, 0, 0, 7, 0, 0, 0);
    expect_out("r7_retire", 0, BYP ? 32'h78 : 32'h77, 0);
    chk();
    tick();
    drv(0, 0, 0, 7, 1, 7, 1, 0, 0);
    expect_out("r7_clear", 32'h78, 32'h78, 0);
    chk();
    drv(1, 9, 32'h55AA55AA, 9, 1, 9, 1, 0, 0);
    expect_out("r9_both", BYP ? 32'h55AA55AA : 32'h0, BYP ? 32'h55AA55AA : 32'h0, 0);
    chk();
    tick();
    drv(0, 0, 0, 9, 1, 9, 1, 0, 0);
    expect_out("r9_stored", 32'h55AA55AA, 32'h55AA55AA, 0);
    chk();
    drv(0, 0, 0, 10, 0, 10, 0, 1, 10);
    expect_out("issue_r10", 0, 0, 0);
    chk();
    tick();
    drv(0, 0, 0, 10, 0, 10, 1, 0, 0);
    expect_out("r10_use_b", 0, 0, 1);
    chk();
    drv(0, 0, 0, 10, 1, 10, 0, 0, 0);
    expect_out("r10_use_a", 0, 0, 1);
    chk();
    drv(0, 0, 0, 10, 0, 10, 0, 0, 0);
    expect_out("r10_unused", 0, 0, 0);
    chk();
    reset = 1'b1;
    drv(1, 4, 32'hFFFFFFFF, 4, 0, 6, 0, 1, 6);
    tick();
    reset = 1'b0;
    drv(0, 0, 0, 4, 1, 10, 1, 0, 0);
    expect_out("rst_r4_r10", 0, 0, 0);
    chk();
    drv(0, 0, 0, 6, 1, 5, 1, 0, 0);
    expect_out("rst_r6_r5", 0, 0, 0);
    chk();
    drv(0, 0, 0, 3, 1, 9, 1, 0, 0);
    expect_out("rst_r3_r9", 0, 0, 0);
    chk();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 1, 0, 1, 0, 0);
    expect_out("r0_never_pending", 0, 0, 0);
    chk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file and write-tracking scoreboard at the consumer end of the writeback interface. It accepts the writeback stage's data, write-enable and destination index, stores the value in one of 16 32-bit registers, and serves two combinational read ports to decode. A per-register pending scoreboard is set when decode issues a writer and cleared when that write retires. From it the block raises a hazard flag so decode can stall.

## Interface
- NUM_REGS, 16, number of architectural registers
- REG_ADDR_W, 4, register index width
- XLEN, 32, data width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- wb_data_in  input  XLEN  writeback data
- wb_write_in  input  1  writeback write enable
- wb_rd_in  input  REG_ADDR_W  writeback destination index
- rs_a_in  input  REG_ADDR_W  read port A index
- rs_b_in  input  REG_ADDR_W  read port B index
- rs_a_data_out  output  XLEN  read port A data, combinational
- rs_b_data_out  output  XLEN  read port B data, combinational
- issue_valid_in  input  1  decode issues an instruction this cycle (not stalled)
- issue_writes_in  input  1  issued instruction writes a register
- issue_rd_in  input  REG_ADDR_W  issued instruction's destination
- use_a_in  input  1  current decode instruction reads rs_a
- use_b_in  input  1  current decode instruction reads rs_b
- hazard_out  output  1  a used source is pending; decode must stall

## Operation
- Register r0 reads as 0 always; writes to r0 are ignored; r0 is never pending.
- Write: on clk edge with wb_write_in=1 and wb_rd_in!=0, regs[wb_rd_in] <= wb_data_in.
- Read: rs_x_data_out = regs[rs_x_in], subject to bypass (Configuration).
- Scoreboard: pending[i] set on edge when issue_valid_in & issue_writes_in & issue_rd_in==i (i!=0); cleared on edge when wb_write_in & wb_rd_in==i.
- Same-cycle set and clear of the same index: set wins (newer writer in flight).
- hazard_out = (use_a_in & pending[rs_a_in] & !bypass_hit_a) | (use_b_in & pending[rs_b_in] & !bypass_hit_b); bypass_hit_x = 0 when bypass compiled out.
- Decode must not assert issue_valid_in while hazard_out=1.

## Timing
- Reset (synchronous): all regs <= 0, all pending <= 0; consequently read outputs are 0 and hazard_out is 0 in the cycle after reset.
- Reset asserted mid-operation overrides any same-cycle write or issue.
- Write latency: value visible in storage one edge after wb_write_in; read path zero cycles.
- Scoreboard set/clear visible one edge after the event.

## Configuration
- REGFILE_BYPASS_EN defined: when wb_write_in=1, wb_rd_in!=0 and rs_x_in==wb_rd_in, rs_x_data_out = wb_data_in in the same cycle, and bypass_hit_x=1 so that source causes no hazard.
- Undefined: reads return stored value only; a pending source being written this cycle still raises hazard_out; decode stalls one extra cycle.

## Structure
- Shared package: NUM_REGS, REG_ADDR_W, XLEN, reg index typedef, R0 constant.
- One sub-module: reg_scoreboard (pending bit vector, set/clear/priority, reset).
- Storage, write logic, bypass mux and hazard combine stay in wb_regfile.

## Test plan
- Reset, then read all indices -> every rs_x_data_out = 0, hazard_out = 0.
- Write r5=0xDEADBEEF, next cycle read rs_a=5 -> 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
- Issue writer to r3, next cycle use_a_in=1, rs_a=3 -> hazard_out=1 until wb write to r3 retires; with REGFILE_BYPASS_EN hazard drops and data 0xCAFEF00D appears in the write cycle; without, one cycle later.
- Same cycle: issue writer to r7 and wb write to r7 -> pending[7] stays 1, r7 updated.
- Both ports read r9 while wb writes r9=0x55AA55AA with bypass -> both outputs 0x55AA55AA same cycle.
- Assert reset in a cycle with wb write r4=0xFFFFFFFF and issue to r6 -> r4 = 0, pending[6] = 0 afterwards.
